// File: rtl/arp_cache_pkg.sv
// Shared types and constants for the ARP resolution cache.
// Holds the broadcast/ethertype constants used across the UDP/IP stack,
// the table entry record, the lookup FSM state encoding and the filter
// deciding whether an (ip, mac) pair may be learned.
package arp_cache_pkg;

    localparam logic [31:0] BROADCAST_IP   = 32'hFFFF_FFFF;
    localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

    // Storage width of the per-entry age field; the cache's AGE_W must not exceed it.
    localparam int ARP_AGE_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          ip;
        logic [47:0]          mac;
        logic [ARP_AGE_W-1:0] age;
    } arp_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_RESP  = 2'd2
    } arp_cache_state_e;

    // Pairs that must never enter the table: null/broadcast IP, broadcast or multicast MAC.
    function automatic logic upd_learnable(input logic [31:0] ip, input logic [47:0] mac);
        return (ip != 32'h0000_0000) && (ip != BROADCAST_IP) &&
               (mac != BROADCAST_MAC) && (mac[40] == 1'b0);
    endfunction

endpackage

// File: rtl/arp_cache_if.sv
// Update / lookup / response handshake bundle of the ARP cache.
// master: the stack side (ARP parser + UDP TX); slave: the cache itself.
interface arp_cache_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_ip;
    logic [47:0] upd_mac;
    logic        lkp_valid;
    logic        lkp_ready;
    logic [31:0] lkp_ip;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [47:0] rsp_mac;

    modport master (
        output upd_valid, upd_ip, upd_mac, lkp_valid, lkp_ip, rsp_ready,
        input  upd_ready, lkp_ready, rsp_valid, rsp_hit, rsp_mac
    );

    modport slave (
        input  upd_valid, upd_ip, upd_mac, lkp_valid, lkp_ip, rsp_ready,
        output upd_ready, lkp_ready, rsp_valid, rsp_hit, rsp_mac
    );
endinterface

// File: rtl/arp_cache_match.sv
// Combinational associative compare over the ARP table.
// Returns whether a valid entry holds the key IP (and the lowest such index),
// plus the lowest-index free slot. Used by both the lookup and the update path.
module arp_cache_match #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic [ENTRIES-1:0] valid,
    input  logic [31:0]        ips [ENTRIES],
    input  logic [31:0]        key,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               free_any,
    output logic [IDX_W-1:0]   free_idx
);

    // Scan from the top down so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (ips[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end else begin
                hit     = hit;
            end
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                free_any = free_any;
            end
        end
    end

endmodule

// File: rtl/arp_cache.sv
// IPv4 -> MAC resolution table for the UDP/IP stack.
// Learns (ip, mac) pairs from the ARP parser and answers lookups from the UDP
// TX path through a three-state IDLE/MATCH/RESP FSM (2-cycle latency).
// Replacement: same-IP overwrite, else lowest free slot, else round-robin victim.
// Optional entry aging is compiled in with `define ARP_CACHE_AGING_EN.
module arp_cache
    import arp_cache_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int AGE_W   = ARP_AGE_W,
    parameter int AGE_MAX = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    arp_cache_if.slave               bus,
    input  logic                     flush,
    input  logic                     age_tick,
    output logic [$clog2(ENTRIES):0] occupancy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    arp_entry_t       tbl_r [ENTRIES];
    logic [IDX_W-1:0] victim_r;
    arp_cache_state_e state_r;
    arp_cache_state_e state_n;
    logic [31:0]      lkp_ip_r;
    logic             rsp_hit_r;
    logic [47:0]      rsp_mac_r;
    logic [OCC_W-1:0] occ_r;

    logic [ENTRIES-1:0] valid_s;
    logic [31:0]        ip_s [ENTRIES];
    logic [OCC_W-1:0]   occ_cnt_s;
    logic               upd_fire_s;
    logic               upd_take_s;
    logic               lkp_fire_s;
    logic               lkp_hit_s;
    logic [IDX_W-1:0]   lkp_idx_s;
    logic               upd_hit_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic               upd_free_s;
    logic [IDX_W-1:0]   upd_free_idx_s;
    logic [IDX_W-1:0]   slot_s;
    logic               evict_s;
    logic               lkp_free_unused_s;
    logic [IDX_W-1:0]   lkp_free_idx_unused_s;

    // Flatten the table into the compare unit's inputs.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_s[i] = tbl_r[i].valid;
            ip_s[i]    = tbl_r[i].ip;
        end
    end

    arp_cache_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lkp_match (
        .valid    (valid_s),
        .ips      (ip_s),
        .key      (lkp_ip_r),
        .hit      (lkp_hit_s),
        .hit_idx  (lkp_idx_s),
        .free_any (lkp_free_unused_s),
        .free_idx (lkp_free_idx_unused_s)
    );

    arp_cache_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_upd_match (
        .valid    (valid_s),
        .ips      (ip_s),
        .key      (bus.upd_ip),
        .hit      (upd_hit_s),
        .hit_idx  (upd_idx_s),
        .free_any (upd_free_s),
        .free_idx (upd_free_idx_s)
    );

    // Flush owns the table for its cycle, so updates are refused while it is high.
    assign bus.upd_ready = !rst && !flush;
    assign bus.lkp_ready = !rst && (state_r == ST_IDLE);
    assign bus.rsp_valid = (state_r == ST_RESP);
    assign bus.rsp_hit   = rsp_hit_r;
    assign bus.rsp_mac   = rsp_mac_r;
    assign occupancy     = occ_r;

    assign upd_fire_s = bus.upd_valid && bus.upd_ready;
    assign upd_take_s = upd_fire_s && upd_learnable(bus.upd_ip, bus.upd_mac);
    assign lkp_fire_s = bus.lkp_valid && bus.lkp_ready;

    // Slot choice: refresh same IP, else lowest free slot, else round-robin victim.
    always_comb begin
        slot_s  = '0;
        evict_s = 1'b0;
        if (upd_hit_s) begin
            slot_s = upd_idx_s;
        end else if (upd_free_s) begin
            slot_s = upd_free_idx_s;
        end else begin
            slot_s  = victim_r;
            evict_s = 1'b1;
        end
    end

`ifdef ARP_CACHE_AGING_EN
    logic [AGE_W:0] age_nx_s [ENTRIES];

    // Candidate next age of each entry, one bit wider so the limit test cannot wrap.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            age_nx_s[i] = {1'b0, tbl_r[i].age[AGE_W-1:0]} + {{AGE_W{1'b0}}, 1'b1};
        end
    end
`else
    logic unused_cfg_s;

    // Aging is compiled out: the tick, the age limits and the age fields are idle.
    always_comb begin
        unused_cfg_s = ^{age_tick, 32'(AGE_W), 32'(AGE_MAX)};
        for (int i = 0; i < ENTRIES; i++) begin
            unused_cfg_s = unused_cfg_s ^ (^tbl_r[i].age);
        end
    end
`endif

    // Table storage: reset, flush, aging and learning. A write in the same cycle
    // as an aging tick is issued last, so a refreshed entry stays valid at age 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_r[i] <= '0;
            end
            victim_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_r[i].valid <= 1'b0;
                tbl_r[i].age   <= '0;
            end
        end else begin
`ifdef ARP_CACHE_AGING_EN
            if (age_tick) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (tbl_r[i].valid) begin
                        if (age_nx_s[i] >= (AGE_W+1)'(AGE_MAX)) begin
                            tbl_r[i].valid <= 1'b0;
                            tbl_r[i].age   <= ARP_AGE_W'(AGE_MAX);
                        end else begin
                            tbl_r[i].age   <= ARP_AGE_W'(age_nx_s[i][AGE_W-1:0]);
                        end
                    end
                end
            end
`endif
            if (upd_take_s) begin
                tbl_r[slot_s] <= arp_entry_t'{valid: 1'b1, ip: bus.upd_ip,
                                              mac: bus.upd_mac, age: '0};
                if (evict_s) begin
                    victim_r <= victim_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Count of valid entries, registered so it trails the table by one cycle.
    always_comb begin
        occ_cnt_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_cnt_s = occ_cnt_s + OCC_W'(valid_s[i]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_cnt_s;
        end
    end

    // Lookup FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Lookup FSM next state: accept, one compare cycle, hold result until consumed.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lkp_fire_s) begin
                    state_n = ST_MATCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MATCH: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Latch the address being resolved when a lookup is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lkp_ip_r <= '0;
        end else if (lkp_fire_s) begin
            lkp_ip_r <= bus.lkp_ip;
        end else begin
            lkp_ip_r <= lkp_ip_r;
        end
    end

    // Capture the result in MATCH from the table as it stood before this edge;
    // broadcast bypasses the table. Held untouched through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_hit_r <= 1'b0;
            rsp_mac_r <= '0;
        end else if (state_r == ST_MATCH) begin
            if (lkp_ip_r == BROADCAST_IP) begin
                rsp_hit_r <= 1'b1;
                rsp_mac_r <= BROADCAST_MAC;
            end else if (lkp_hit_s) begin
                rsp_hit_r <= 1'b1;
                rsp_mac_r <= tbl_r[lkp_idx_s].mac;
            end else begin
                rsp_hit_r <= 1'b0;
                rsp_mac_r <= '0;
            end
        end else begin
            rsp_hit_r <= rsp_hit_r;
            rsp_mac_r <= rsp_mac_r;
        end
    end

endmodule
